// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue
//
// Instruction queue between fetch and decode. Up to two instructions arrive per
// cycle. Each one is classified as it is written and stored with its PC in a
// circular buffer. The head entry is presented to the consumer with its class.
// A branch or jump is presented only once its delay slot (head+1) is also
// queued. The two then leave together.
//
// Ports
//   clk          rising-edge clock for all state
//   rst          synchronous active-high reset (head/tail/count -> 0)
//   flush        discard all queued entries; beats any push/pop this cycle
//   in_valid     [1:0] slot valid bits; slot1 alone is treated as no push
//   in_inst0/1   instruction words for slot0 / slot1
//   in_pc        PC of slot0 (slot1 is in_pc + 4)
//   in_ready     room for two more entries (registered count only)
//   out_valid    a head bundle is presentable
//   out_inst     head instruction (0 when not valid)
//   out_pc       head PC (PC_RESET when empty)
//   out_cls      head class (0 when not valid)
//   out_ds_inst  entry head+1 (delay slot)
//   out_ds_pc    PC of entry head+1
//   out_ready    consumer accepts the bundle
//   count        number of occupied entries
// -----------------------------------------------------------------------------
module inst_queue #(
  parameter int          DEPTH    = 8,            // power of two, >= 4
  parameter logic [31:0] PC_RESET = 32'hBFC00000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [1:0]               in_valid,
  input  logic [31:0]              in_inst0,
  input  logic [31:0]              in_inst1,
  input  logic [31:0]              in_pc,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [31:0]              out_inst,
  output logic [31:0]              out_pc,
  output logic [2:0]               out_cls,
  output logic [31:0]              out_ds_inst,
  output logic [31:0]              out_ds_pc,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_JUMP   = 3'd4,
    CLS_PRIV   = 3'd5,
    CLS_HILO   = 3'd6,
    CLS_RI     = 3'd7
  } cls_e;

  // Pre-decode of a MIPS32 word into a coarse class used by the consumer.
  function automatic cls_e decode_cls(input logic [31:0] inst);
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] funct;
    cls_e       c;
    op    = inst[31:26];
    rs    = inst[25:21];
    rt    = inst[20:16];
    funct = inst[5:0];
    c     = CLS_RI;
    case (op)
      6'b000000: begin
        case (funct)
          6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
          6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
          6'b100110, 6'b100111, 6'b101010, 6'b101011: c = CLS_ALU;
          6'b001000, 6'b001001:                       c = CLS_JUMP;
          6'b001100, 6'b001101:                       c = CLS_PRIV;
          6'b010000, 6'b010001, 6'b010010, 6'b010011,
          6'b011000, 6'b011001, 6'b011010, 6'b011011: c = CLS_HILO;
          default:                                    c = CLS_RI;
        endcase
      end
      6'b000001: begin
        if (rt == 5'b00000 || rt == 5'b00001 || rt == 5'b10000 || rt == 5'b10001)
          c = CLS_BRANCH;
      end
      6'b000010, 6'b000011:                           c = CLS_JUMP;
      6'b000100, 6'b000101, 6'b000110, 6'b000111:     c = CLS_BRANCH;
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110, 6'b001111:     c = CLS_ALU;
      6'b010000: begin
        if (rs == 5'b00100 || rs == 5'b00000 || rs == 5'b10000)
          c = CLS_PRIV;
      end
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: c = CLS_LOAD;
      6'b101000, 6'b101001, 6'b101011:                c = CLS_STORE;
      default:                                        c = CLS_RI;
    endcase
    return c;
  endfunction

  // Storage: contents are not reset, only the pointers and the count are.
  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [2:0]    cls_mem  [DEPTH];

  logic [AW-1:0] head_reg, head_next;
  logic [AW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;

  logic          push_en;
  logic [CW-1:0] push_cnt;
  logic [CW-1:0] pop_cnt;

  logic [31:0]   slot_inst [2];
  logic [31:0]   slot_pc   [2];
  logic [2:0]    slot_cls  [2];
  logic [AW-1:0] slot_addr [2];
  logic          slot_we   [2];

  logic [2:0]    head_cls;
  logic          head_ctl;
  logic [AW-1:0] ds_addr;

  // Readiness looks only at the registered count. A pop in the same cycle
  // never opens room for a push.
  assign in_ready = (count_reg <= CW'(DEPTH - 2));
  assign push_en  = in_ready & in_valid[0] & ~flush & ~rst;

  // Per-slot write path: data, PC, class and target address.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      if (gi == 0) begin : g_s0
        assign slot_inst[gi] = in_inst0;
        assign slot_we[gi]   = push_en;
      end else begin : g_s1
        assign slot_inst[gi] = in_inst1;
        assign slot_we[gi]   = push_en & in_valid[1];
      end
      assign slot_pc[gi]   = in_pc + 32'(4 * gi);
      assign slot_cls[gi]  = decode_cls(slot_inst[gi]);
      assign slot_addr[gi] = tail_reg + AW'(gi);
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (slot_we[s]) begin
        inst_mem[slot_addr[s]] <= slot_inst[s];
        pc_mem[slot_addr[s]]   <= slot_pc[s];
        cls_mem[slot_addr[s]]  <= slot_cls[s];
      end
    end
  end

  // Head presentation. A branch/jump waits until its delay slot is present.
  assign head_cls = cls_mem[head_reg];
  assign head_ctl = (head_cls == CLS_BRANCH) || (head_cls == CLS_JUMP);
  assign ds_addr  = head_reg + AW'(1);

  always_comb begin
    out_valid   = 1'b0;
    out_inst    = 32'd0;
    out_cls     = 3'd0;
    out_pc      = PC_RESET;
    out_ds_inst = inst_mem[ds_addr];
    out_ds_pc   = pc_mem[ds_addr];
    if (count_reg != '0) begin
      out_pc    = pc_mem[head_reg];
      out_valid = !head_ctl || (count_reg >= CW'(2));
    end
    if (out_valid) begin
      out_inst = inst_mem[head_reg];
      out_cls  = head_cls;
    end
  end

  // Push is blocked unless two entries are free and a pop removes no more
  // than is occupied, so the count can never overflow or underflow.
  always_comb begin
    push_cnt = '0;
    pop_cnt  = '0;
    if (push_en)
      push_cnt = in_valid[1] ? CW'(2) : CW'(1);
    if (out_valid && out_ready)
      pop_cnt = head_ctl ? CW'(2) : CW'(1);

    head_next  = head_reg + pop_cnt[AW-1:0];
    tail_next  = tail_reg + push_cnt[AW-1:0];
    count_next = count_reg + push_cnt - pop_cnt;
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: tb/tb_inst_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_queue
//
// Scoreboard bench for inst_queue (DEPTH = 8).
//
// The driver applies one cycle of stimulus at a time. After the clock edge it
// appends every accepted entry to the scoreboard, with a hand-assigned class.
//
// The monitor runs on the falling edge. It compares the queue outputs with the
// scoreboard head and pops the scoreboard whenever the queue hands over a
// bundle.
// -----------------------------------------------------------------------------
module tb_inst_queue;

  localparam int          DEPTH    = 8;
  localparam logic [31:0] PC_RESET = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [1:0]  in_valid = 2'b00;
  logic [31:0] in_inst0 = '0;
  logic [31:0] in_inst1 = '0;
  logic [31:0] in_pc = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [2:0]  out_cls;
  logic [31:0] out_ds_inst;
  logic [31:0] out_ds_pc;
  logic        out_ready = 1'b0;
  logic [3:0]  count;

  inst_queue #(.DEPTH(DEPTH), .PC_RESET(PC_RESET)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_inst0(in_inst0), .in_inst1(in_inst1), .in_pc(in_pc),
    .in_ready(in_ready), .out_valid(out_valid), .out_inst(out_inst),
    .out_pc(out_pc), .out_cls(out_cls), .out_ds_inst(out_ds_inst),
    .out_ds_pc(out_ds_pc), .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  cls;
  } ent_t;

  ent_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   armed   = 1'b0;

  // Instruction table with hand-decoded classes.
  logic [31:0] tbl_inst [16];
  logic [2:0]  tbl_cls  [16];

  function automatic bit is_ctl(input logic [2:0] c);
    return (c == 3'd3) || (c == 3'd4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus. Called at posedge+1 and returns at the next posedge+1.
  task automatic step(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                      input logic [31:0] pc, input logic [2:0] c0, input logic [2:0] c1,
                      input logic ordy, input logic fl);
    bit acc;
    in_valid  = v;
    in_inst0  = i0;
    in_inst1  = i1;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    acc = !fl && v[0] && ((DEPTH - sb.size()) >= 2);
    @(posedge clk);
    if (fl) begin
      sb.delete();
      $display("[TB] flush");
    end else if (acc) begin
      sb.push_back('{inst: i0, pc: pc, cls: c0});
      $display("[TB] push inst=%h pc=%h", i0, pc);
      if (v[1]) begin
        sb.push_back('{inst: i1, pc: pc + 32'd4, cls: c1});
        $display("[TB] push inst=%h pc=%h", i1, pc + 32'd4);
      end
    end
    #1;
  endtask

  task automatic idle_pop();
    step(2'b00, 32'd0, 32'd0, 32'd0, 3'd0, 3'd0, 1'b1, 1'b0);
  endtask

  // Pops until the queue is empty. A lone branch at the head gets a nop as
  // its delay slot so that it can leave.
  task automatic drain(input string name);
    int n = 0;
    while (sb.size() > 0 && n < 40) begin
      if (sb.size() == 1 && is_ctl(sb[0].cls))
        step(2'b01, 32'h0, 32'h0, 32'h0000_9000, 3'd0, 3'd0, 1'b1, 1'b0);
      else
        idle_pop();
      n++;
    end
    chk({name, "_count"}, 32'(count), 32'd0);
  endtask

  // Monitor: compares the outputs with the scoreboard and pops on handover.
  always @(negedge clk) begin
    if (armed && !rst) begin
      bit exp_valid;
      bit exp_ready;
      exp_ready = (DEPTH - sb.size()) >= 2;
      exp_valid = (sb.size() >= 1) && (!is_ctl(sb[0].cls) || sb.size() >= 2);
      chk("mon_count", 32'(count), 32'(sb.size()));
      chk("mon_in_ready", 32'(in_ready), 32'(exp_ready));
      chk("mon_out_valid", 32'(out_valid), 32'(exp_valid));
      if (!exp_valid) begin
        chk("mon_idle_inst", out_inst, 32'd0);
        chk("mon_idle_cls", 32'(out_cls), 32'd0);
        chk("mon_idle_pc", out_pc, (sb.size() == 0) ? PC_RESET : sb[0].pc);
      end else begin
        chk("mon_head_inst", out_inst, sb[0].inst);
        chk("mon_head_pc", out_pc, sb[0].pc);
        chk("mon_head_cls", 32'(out_cls), 32'(sb[0].cls));
        if (is_ctl(sb[0].cls)) begin
          chk("mon_ds_inst", out_ds_inst, sb[1].inst);
          chk("mon_ds_pc", out_ds_pc, sb[1].pc);
        end
        if (out_ready && !flush) begin
          $display("[TB] pop inst=%h pc=%h cls=%0d", sb[0].inst, sb[0].pc, sb[0].cls);
          if (is_ctl(sb[0].cls)) void'(sb.pop_front());
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] pcv;
    tbl_inst[0]  = 32'h24020005; tbl_cls[0]  = 3'd0;  // addiu
    tbl_inst[1]  = 32'h00000000; tbl_cls[1]  = 3'd0;  // sll (nop)
    tbl_inst[2]  = 32'h10000003; tbl_cls[2]  = 3'd3;  // beq
    tbl_inst[3]  = 32'h8C410004; tbl_cls[3]  = 3'd1;  // lw
    tbl_inst[4]  = 32'hAC410004; tbl_cls[4]  = 3'd2;  // sw
    tbl_inst[5]  = 32'h08000010; tbl_cls[5]  = 3'd4;  // j
    tbl_inst[6]  = 32'h03E00008; tbl_cls[6]  = 3'd4;  // jr
    tbl_inst[7]  = 32'h04110002; tbl_cls[7]  = 3'd3;  // bgezal
    tbl_inst[8]  = 32'h00850018; tbl_cls[8]  = 3'd6;  // mult
    tbl_inst[9]  = 32'h0000000C; tbl_cls[9]  = 3'd5;  // syscall
    tbl_inst[10] = 32'h40806000; tbl_cls[10] = 3'd5;  // mtc0
    tbl_inst[11] = 32'hFC000000; tbl_cls[11] = 3'd7;  // reserved
    tbl_inst[12] = 32'h00851025; tbl_cls[12] = 3'd0;  // or
    tbl_inst[13] = 32'h3C011234; tbl_cls[13] = 3'd0;  // lui
    tbl_inst[14] = 32'h00000011; tbl_cls[14] = 3'd6;  // mthi
    tbl_inst[15] = 32'h7C000000; tbl_cls[15] = 3'd7;  // reserved

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_cls", 32'(out_cls), 32'd0);
    chk("rst_out_pc", out_pc, PC_RESET);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    rst = 1'b0;
    sb.delete();
    armed = 1'b1;

    // Dual push, then single pops
    step(2'b11, 32'h24020005, 32'h00000000, 32'h1000, 3'd0, 3'd0, 1'b0, 1'b0);
    chk("dual_count", 32'(count), 32'd2);
    chk("dual_valid", 32'(out_valid), 32'd1);
    chk("dual_cls", 32'(out_cls), 32'd0);
    chk("dual_pc", out_pc, 32'h1000);
    idle_pop();
    chk("pop1_pc", out_pc, 32'h1004);
    chk("pop1_count", 32'(count), 32'd1);
    idle_pop();
    chk("pop2_count", 32'(count), 32'd0);

    // Branch waits for its delay slot
    step(2'b01, 32'h10000003, 32'h0, 32'h2000, 3'd3, 3'd0, 1'b0, 1'b0);
    chk("br_alone_count", 32'(count), 32'd1);
    chk("br_alone_valid", 32'(out_valid), 32'd0);
    chk("br_alone_pc", out_pc, 32'h2000);
    step(2'b01, 32'h00000000, 32'h0, 32'h2004, 3'd0, 3'd0, 1'b0, 1'b0);
    chk("br_ds_valid", 32'(out_valid), 32'd1);
    chk("br_ds_cls", 32'(out_cls), 32'd3);
    chk("br_ds_pc", out_ds_pc, 32'h2004);
    idle_pop();
    chk("br_pop_count", 32'(count), 32'd0);

    // Fill to full, ignored push, in_ready on the registered count only
    for (int k = 0; k < 4; k++)
      step(2'b11, 32'h24020005, 32'h24020005, 32'h3000 + 32'(8 * k), 3'd0, 3'd0, 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'd8);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    step(2'b11, 32'hDEADBEEF, 32'hDEADBEEF, 32'h4000, 3'd7, 3'd7, 1'b0, 1'b0);
    chk("full_ignore_count", 32'(count), 32'd8);
    idle_pop();
    chk("full_pop1_count", 32'(count), 32'd7);
    chk("full_pop1_ready", 32'(in_ready), 32'd0);
    idle_pop();
    chk("full_pop2_ready", 32'(in_ready), 32'd1);
    drain("full_drain");

    // Class decoding of the harder cases
    step(2'b01, 32'hFC000000, 32'h0, 32'h5000, 3'd7, 3'd0, 1'b0, 1'b0);
    chk("cls_ri", 32'(out_cls), 32'd7);
    idle_pop();
    step(2'b01, 32'h42000018, 32'h0, 32'h5004, 3'd5, 3'd0, 1'b0, 1'b0);
    chk("cls_eret", 32'(out_cls), 32'd5);
    idle_pop();
    step(2'b01, 32'h0000000C, 32'h0, 32'h5008, 3'd5, 3'd0, 1'b0, 1'b0);
    chk("cls_syscall", 32'(out_cls), 32'd5);
    idle_pop();
    step(2'b01, 32'h00850018, 32'h0, 32'h500C, 3'd6, 3'd0, 1'b0, 1'b0);
    chk("cls_mult", 32'(out_cls), 32'd6);
    idle_pop();
    chk("cls_end_count", 32'(count), 32'd0);

    // Slot1 valid without slot0 is no push
    step(2'b10, 32'h24020005, 32'h24020005, 32'h5100, 3'd0, 3'd0, 1'b0, 1'b0);
    chk("v10_count", 32'(count), 32'd0);

    // Flush beats a simultaneous push and pop
    step(2'b11, 32'h24020005, 32'h00851025, 32'h6000, 3'd0, 3'd0, 1'b0, 1'b0);
    step(2'b01, 32'h3C011234, 32'h0, 32'h6008, 3'd0, 3'd0, 1'b0, 1'b0);
    chk("pre_flush_count", 32'(count), 32'd3);
    step(2'b11, 32'h24020005, 32'h24020005, 32'h6100, 3'd0, 3'd0, 1'b1, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);

    // Random mixed traffic, checked by the monitor
    pcv = 32'h7000;
    for (int k = 0; k < 20; k++) begin
      int a;
      int b;
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      step(2'($urandom_range(0, 3)), tbl_inst[a], tbl_inst[b], pcv,
           tbl_cls[a], tbl_cls[b], 1'($urandom_range(0, 1)), 1'b0);
      pcv = pcv + 32'd8;
    end
    drain("rand_drain");

    in_valid  = 2'b00;
    out_ready = 1'b0;
    flush     = 1'b0;
    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
